// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and helpers for the SHA-256 message padder
// Purpose: FSM state encoding, the 0x80 pad constant and the last-word
//          byte-mask helpers used by sha256_padder.
// Ports:   none (package).
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_PAD       = 3'd1,
        ST_LEN       = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_DONE_WAIT = 3'd4
    } pad_state_t;

    localparam logic [7:0]  PAD_BYTE = 8'h80;
    localparam logic [31:0] PAD_WORD = {PAD_BYTE, 24'h0};

    // Mask keeping the n leading (most significant) bytes; n=0 means all four.
    function automatic logic [31:0] byte_mask(input logic [1:0] n);
        logic [31:0] m;
        case (n)
            2'd1:    m = 32'hFF00_0000;
            2'd2:    m = 32'hFFFF_0000;
            2'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Final partial word: keep n leading bytes, 0x80 in byte n, zeros after.
    function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                  input logic [1:0]  n);
        logic [31:0] marker;
        case (n)
            2'd1:    marker = {8'h0, PAD_BYTE, 16'h0};
            2'd2:    marker = {16'h0, PAD_BYTE, 8'h0};
            2'd3:    marker = {24'h0, PAD_BYTE};
            default: marker = 32'h0;
        endcase
        return (data & byte_mask(n)) | marker;
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// rtl/sha256_padder_if.sv - message word stream into the SHA-256 padder
// Purpose: groups the word-stream handshake.
// Signals: s_data  - 32-bit word, s_data[31:24] is the earliest byte
//          s_valid - word/last/bytes valid
//          s_last  - final word of the message
//          s_bytes - valid bytes in the final word (0 means 4)
//          s_ready - word accepted when s_valid && s_ready
// Modports: master = word source, slave = padder.
interface sha256_padder_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [1:0]  s_bytes;
    logic        s_ready;

    modport master (output s_data, output s_valid, output s_last,
                    output s_bytes, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last,
                    input s_bytes, output s_ready);
endinterface

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - packs a byte message into padded 512-bit SHA-256 blocks
// Purpose: collects 32-bit message words into a 16-word block buffer, appends
//          the 0x80 marker, zero fill and 64-bit bit length, and hands each
//          block to the hash core with an init (first) or next pulse.
// Ports:   clk, reset_n          - clock, asynchronous active-low reset
//          s_if (slave)          - message word stream
//          core_ready            - hash core may accept init/next
//          core_digest_valid     - hash core digest valid
//          core_init / core_next - one-cycle block issue pulses
//          core_block            - block buffer, word 0 in [511:480]
//          msg_done              - one-cycle pulse when final digest is valid
//          busy                  - low only while idle awaiting a new message
module sha256_padder
    import sha256_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    sha256_padder_if.slave         s_if,
    input  logic                   core_ready,
    input  logic                   core_digest_valid,
    output logic                   core_init,
    output logic                   core_next,
    output logic [511:0]           core_block,
    output logic                   msg_done,
    output logic                   busy
);

    pad_state_t  state, state_nxt;
    logic [4:0]  widx;
    logic [63:0] len;
    logic        first_blk;
    logic        pend80;
    logic        final_blk;
    logic        padding;
    logic [31:0] words [16];
    logic        ready_o;
    logic        accept;
    logic        part_last;

    assign s_if.s_ready = ready_o;
    assign accept       = s_if.s_valid && ready_o;
    // Final word with 1..3 bytes carries its own 0x80 marker.
    assign part_last    = s_if.s_last && (s_if.s_bytes != 2'd0);
    assign busy         = !((state == ST_FILL) && (widx == 5'd0) && first_blk);

    for (genvar g = 0; g < 16; g++) begin : g_blk
        assign core_block[511-32*g -: 32] = words[g];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (s_if.s_last) begin
                        state_nxt = ST_PAD;
                    end else if (widx == 5'd15) begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_PAD: begin
                if (widx == 5'd16) begin
                    state_nxt = ST_ISSUE;
                end else if (!pend80 && (widx == 5'd14)) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (widx == 5'd15) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_ready) begin
                    if (final_blk) begin
                        state_nxt = ST_DONE_WAIT;
                    end else if (padding) begin
                        state_nxt = ST_PAD;
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_DONE_WAIT: begin
                if (core_digest_valid) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // Outputs; s_ready is forced low while reset is asserted.
    always_comb begin
        ready_o   = 1'b0;
        core_init = 1'b0;
        core_next = 1'b0;
        msg_done  = 1'b0;
        case (state)
            ST_FILL:      ready_o  = reset_n && !widx[4];
            ST_ISSUE: begin
                core_init = core_ready && first_blk;
                core_next = core_ready && !first_blk;
            end
            ST_DONE_WAIT: msg_done = core_digest_valid;
            default: ;
        endcase
    end

    // Block buffer, word index, bit counter and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            widx      <= 5'd0;
            len       <= 64'd0;
            first_blk <= 1'b1;
            pend80    <= 1'b0;
            final_blk <= 1'b0;
            padding   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                words[i] <= 32'h0;
            end
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        widx <= widx + 5'd1;
                        if (part_last) begin
                            words[widx[3:0]] <= pad_last_word(s_if.s_data, s_if.s_bytes);
                            len              <= len + {59'd0, s_if.s_bytes, 3'd0};
                        end else begin
                            words[widx[3:0]] <= s_if.s_data;
                            len              <= len + 64'd32;
                        end
                        if (s_if.s_last) begin
                            padding <= 1'b1;
                            pend80  <= (s_if.s_bytes == 2'd0);
                        end else if (widx == 5'd15) begin
                            final_blk <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (widx == 5'd16) begin
                        final_blk <= 1'b0;
                    end else if (pend80) begin
                        words[widx[3:0]] <= PAD_WORD;
                        pend80           <= 1'b0;
                        widx             <= widx + 5'd1;
                    end else if (widx != 5'd14) begin
                        words[widx[3:0]] <= 32'h0;
                        widx             <= widx + 5'd1;
                    end
                end
                ST_LEN: begin
                    if (widx == 5'd14) begin
                        words[14] <= len[63:32];
                        widx      <= 5'd15;
                    end else begin
                        words[15] <= len[31:0];
                        widx      <= 5'd16;
                        final_blk <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Slots stay untouched until the block has been handed off.
                    if (core_ready) begin
                        first_blk <= 1'b0;
                        widx      <= 5'd0;
                    end
                end
                ST_DONE_WAIT: begin
                    if (core_digest_valid) begin
                        first_blk <= 1'b1;
                        len       <= 64'd0;
                        padding   <= 1'b0;
                        final_blk <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - randomized self-checking bench for sha256_padder
module tb_sha256_padder;

    typedef logic [7:0] byte_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         core_idle = 1'b1;
    logic         hold_ready = 1'b0;
    logic         core_ready;
    logic         core_digest_valid = 1'b0;
    logic         core_init, core_next, msg_done, busy;
    logic [511:0] core_block;

    int total = 0;
    int bad = 0;
    int mdone_cnt = 0;
    int pulse_cnt = 0;
    int core_seen = 0;
    int busy_cnt = 0;
    bit prev_pulse = 1'b0;

    logic [511:0] got_blk[$];
    bit           got_init[$];
    logic [511:0] exp_blk[$];

    sha256_padder_if sif();

    assign core_ready = core_idle && !hold_ready;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .s_if              (sif),
        .core_ready        (core_ready),
        .core_digest_valid (core_digest_valid),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_block        (core_block),
        .msg_done          (msg_done),
        .busy              (busy)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wrd(input logic [511:0] b, input int i);
        return b[511-32*i -: 32];
    endfunction

    // Block monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (core_init || core_next) begin
                got_blk.push_back(core_block);
                got_init.push_back(core_init);
                check("pulse_excl", {core_init & core_next, prev_pulse}, 2'b00);
                pulse_cnt++;
            end
            prev_pulse = core_init || core_next;
            if (msg_done) mdone_cnt++;
        end
    end

    // Hash core: busy for a few cycles after each block, then digest pulse.
    always @(posedge clk) begin
        #1;
        core_digest_valid = 1'b0;
        if (pulse_cnt != core_seen) begin
            core_seen = pulse_cnt;
            core_idle = 1'b0;
            busy_cnt  = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                core_idle         = 1'b1;
                core_digest_valid = 1'b1;
            end
        end
    end

    // Reference: standard SHA-256 padding over a byte array.
    task automatic build_exp(input byte_t m[$]);
        byte_t        p[$];
        logic [63:0]  bits;
        logic [511:0] b;
        p = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        exp_blk.delete();
        for (int i = 0; i < p.size() / 64; i++) begin
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*i+j];
            exp_blk.push_back(b);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb);
        int t;
        sif.s_data  = d;
        sif.s_last  = l;
        sif.s_bytes = nb;
        sif.s_valid = 1'b1;
        t = 0;
        while (!sif.s_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("ready_timeout", sif.s_ready, 1'b1);
        @(posedge clk); #1;
        sif.s_valid = 1'b0;
        sif.s_data  = $urandom;
    endtask

    task automatic send_msg(input byte_t m[$]);
        int          nw;
        logic [31:0] w;
        logic        l;
        nw = (m.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;  // bytes past the end of the message are junk
            for (int k = 0; k < 4; k++) begin
                if (4*i + k < m.size()) w[31-8*k -: 8] = m[4*i+k];
            end
            l = (i == nw - 1);
            send_word(w, l, l ? 2'(m.size() % 4) : 2'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic finish_msg(input string name, input byte_t m[$], input int start);
        int t;
        t = 0;
        while (mdone_cnt == start && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_msg_done", name), mdone_cnt, start + 1);
        repeat (4) @(negedge clk);
        check($sformatf("%s_single_done", name), mdone_cnt, start + 1);
        build_exp(m);
        check($sformatf("%s_nblk", name), got_blk.size(), exp_blk.size());
        for (int i = 0; i < got_blk.size() && i < exp_blk.size(); i++) begin
            check($sformatf("%s_blk%0d", name, i), got_blk[i], exp_blk[i]);
            check($sformatf("%s_kind%0d", name, i), got_init[i], (i == 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic run_msg(input string name, input byte_t m[$]);
        int start;
        got_blk.delete();
        got_init.delete();
        start = mdone_cnt;
        send_msg(m);
        finish_msg(name, m, start);
    endtask

    function automatic void rand_msg(input int n, output byte_t m[$]);
        m.delete();
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t m[$];
        byte_t abc[$];
        logic [511:0] snap;
        int viol, start, n0;
        int lens[8];

        abc = '{8'h61, 8'h62, 8'h63};
        reset_n     = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 32'h0;
        sif.s_last  = 1'b0;
        sif.s_bytes = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", sif.s_ready, 1'b0);
        check("rst_block", core_block, 512'h0);
        check("rst_pulses", {core_init, core_next, msg_done}, 3'b000);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_s_ready", sif.s_ready, 1'b1);

        // "abc"
        run_msg("abc", abc);
        if (got_blk.size() > 0) begin
            check("abc_w0", wrd(got_blk[0], 0), 32'h61626380);
            check("abc_w15", wrd(got_blk[0], 15), 32'h00000018);
            check("abc_init", got_init[0], 1'b1);
        end

        // 56 bytes: length spills into a second block
        rand_msg(56, m);
        run_msg("m56", m);
        if (got_blk.size() == 2) begin
            check("m56_b1w14", wrd(got_blk[0], 14), 32'h80000000);
            check("m56_b1w15", wrd(got_blk[0], 15), 32'h0);
            check("m56_b2w15", wrd(got_blk[1], 15), 32'h000001C0);
        end

        // 64 bytes with the core held off while the first block waits
        rand_msg(64, m);
        got_blk.delete();
        got_init.delete();
        start = mdone_cnt;
        hold_ready = 1'b1;
        send_msg(m);
        repeat (3) @(negedge clk);
        snap = core_block;
        n0 = got_blk.size();
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (core_init || core_next || sif.s_ready || core_block !== snap) viol++;
        end
        check("stall_quiet", viol, 0);
        check("stall_no_pulse", got_blk.size(), n0);
        @(posedge clk); #1;
        hold_ready = 1'b0;
        @(negedge clk);
        check("stall_release_init", core_init, 1'b1);
        @(posedge clk); #1;
        finish_msg("m64", m, start);
        if (got_blk.size() == 2) begin
            check("m64_b2w0", wrd(got_blk[1], 0), 32'h80000000);
            check("m64_b2w15", wrd(got_blk[1], 15), 32'h00000200);
        end

        // Reset part-way through a message, then "abc"
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 2'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        check("midrst_block", core_block, 512'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_msg("rst_abc", abc);
        if (got_blk.size() > 0) begin
            check("rst_abc_w0", wrd(got_blk[0], 0), 32'h61626380);
            check("rst_abc_init", got_init[0], 1'b1);
        end

        // Back-to-back messages around block boundaries plus random sizes
        lens = '{1, 4, 55, 57, 63, 119, 0, 0};
        lens[6] = $urandom_range(1, 150);
        lens[7] = $urandom_range(1, 150);
        for (int i = 0; i < 8; i++) begin
            rand_msg(lens[i], m);
            run_msg($sformatf("b2b%0d_len%0d", i, lens[i]), m);
        end
        run_msg("abc_again", abc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
